// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    BURST  = 2'd2,
    WRDONE = 2'd3
  } sdram_arb_state_e;

  localparam int   BURST_LEN_DEF = 4;
  localparam logic OWNER_A       = 1'b0;
  localparam logic OWNER_B       = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: on a tie the port not granted last wins.
module rr_arbiter2
  import sdram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = OWNER_A;
    if (req_a && req_b) begin
      grant_id = (last_grant == OWNER_A) ? OWNER_B : OWNER_A;
    end else if (req_b) begin
      grant_id = OWNER_B;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between an instruction cache (A) and a data cache (B).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [15:0]       a_wdata,
  output logic              a_fill,
  output logic              a_ack,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [15:0]       b_wdata,
  output logic              b_fill,
  output logic              b_ack,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [15:0]       mem_wdata,
  input  logic              mem_fill,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output sdram_arb_state_e  state_o
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

  // Handshake: a requester holds req (with stable addr/rw/wdata) until it sees its
  // first fill (read) or its ack (write); dropping req earlier aborts the grant.
  sdram_arb_state_e  state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rw_q, mem_rw_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d;

  logic grant_valid, grant_id;
  logic owner_req;
  logic [CNT_W-1:0] cnt_inc;

  rr_arbiter2 u_rr (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign owner_req = (owner_q == OWNER_B) ? b_req : a_req;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_rw_d     = mem_rw_q;
    mem_wdata_d  = mem_wdata_q;
    mem_req_d    = mem_req_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          cnt_d        = '0;
          mem_addr_d   = (grant_id == OWNER_B) ? b_addr  : a_addr;
          mem_rw_d     = (grant_id == OWNER_B) ? b_rw    : a_rw;
          mem_wdata_d  = (grant_id == OWNER_B) ? b_wdata : a_wdata;
          mem_req_d    = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (mem_rw_q && mem_fill) begin
          cnt_d     = CNT_W'(1);
          mem_req_d = 1'b0;
          state_d   = (LAST_CNT == CNT_W'(1)) ? IDLE : BURST;
        end else if (!mem_rw_q && mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = WRDONE;
        end else if (!owner_req) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      BURST: begin
        if (mem_fill) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) state_d = IDLE;
        end
      end
      WRDONE: begin
        // Wait for release so a write req still held is not granted a second time.
        if (!owner_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_A;
      last_grant_q <= OWNER_B;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_rw_q     <= 1'b1;
      mem_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_rw_q     <= mem_rw_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_req_q    <= mem_req_d;
    end
  end

  // Fill strobes are combinational: the caches write their data RAM on the fill cycle.
  assign a_fill    = mem_fill & (owner_q == OWNER_A) & ((state_q == REQ) | (state_q == BURST));
  assign b_fill    = mem_fill & (owner_q == OWNER_B) & ((state_q == REQ) | (state_q == BURST));
  assign a_ack     = mem_ack & (owner_q == OWNER_A) & (state_q == REQ);
  assign b_ack     = mem_ack & (owner_q == OWNER_B) & (state_q == REQ);
  assign rdata     = mem_rdata;
  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign busy      = (state_q != IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a transaction-level reference model.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int BL = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_req, b_req, a_rw, b_rw;
  logic [15:0]   a_wdata, b_wdata;
  logic          a_fill, a_ack, b_fill, b_ack;
  logic [15:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_req, mem_rw;
  logic [15:0]   mem_wdata;
  logic          mem_fill, mem_ack;
  logic [15:0]   mem_rdata;
  logic          busy;
  sdram_arb_state_e state_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sdram_port_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_req(a_req), .a_rw(a_rw), .a_wdata(a_wdata),
    .a_fill(a_fill), .a_ack(a_ack),
    .b_addr(b_addr), .b_req(b_req), .b_rw(b_rw), .b_wdata(b_wdata),
    .b_fill(b_fill), .b_ack(b_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_fill(mem_fill), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One transaction in flight: who owns it, whether the downstream request is still
  // outstanding, how many words came back, and whether we await the owner's release.
  bit            m_busy = 0, m_pending = 0, m_release = 0;
  bit            m_owner = 0, m_last = 1, m_read = 1, m_oreq;
  int            m_words = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_wdata = '0;

  always @(posedge clk) begin
    m_oreq = m_owner ? b_req : a_req;
    if (!reset) begin
      m_busy = 0; m_pending = 0; m_release = 0; m_owner = 0; m_last = 1;
      m_read = 1; m_words = 0; m_addr = '0; m_wdata = '0;
    end else if (!m_busy) begin
      if (a_req || b_req) begin
        m_owner   = (a_req && b_req) ? !m_last : (b_req && !a_req);
        m_last    = m_owner;
        m_busy    = 1; m_pending = 1; m_release = 0; m_words = 0;
        m_addr    = m_owner ? b_addr : a_addr;
        m_read    = m_owner ? b_rw : a_rw;
        m_wdata   = m_owner ? b_wdata : a_wdata;
      end
    end else if (m_release) begin
      if (!m_oreq) m_busy = 0;
    end else if (m_pending) begin
      if (m_read && mem_fill) begin
        m_pending = 0; m_words = 1;
        if (m_words == BL) m_busy = 0;
      end else if (!m_read && mem_ack) begin
        m_pending = 0; m_release = 1;
      end else if (!m_oreq) begin
        m_pending = 0; m_busy = 0;
      end
    end else if (mem_fill) begin
      m_words++;
      if (m_words == BL) m_busy = 0;
    end
  end

  function automatic sdram_arb_state_e exp_state();
    if (!m_busy) return IDLE;
    if (m_pending) return REQ;
    if (m_release) return WRDONE;
    return BURST;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.busy",      32'(busy),      32'(m_busy));
      chk("m.mem_req",   32'(mem_req),   32'(m_busy && m_pending));
      chk("m.mem_addr",  mem_addr,       m_addr);
      chk("m.mem_rw",    32'(mem_rw),    32'(m_read));
      chk("m.mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("m.a_fill",    32'(a_fill),    32'(mem_fill && m_busy && !m_release && !m_owner));
      chk("m.b_fill",    32'(b_fill),    32'(mem_fill && m_busy && !m_release && m_owner));
      chk("m.a_ack",     32'(a_ack),     32'(mem_ack && m_busy && m_pending && !m_owner));
      chk("m.b_ack",     32'(b_ack),     32'(mem_ack && m_busy && m_pending && m_owner));
      chk("m.rdata",     32'(rdata),     32'(mem_rdata));
      chk("m.state",     32'(state_o),   32'(exp_state()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives BL fill words base*1..base*BL; the owner drops req after the first word.
  task automatic burst(input bit is_b, input logic [15:0] base);
    logic [15:0] d;
    for (int i = 0; i < BL; i++) begin
      d = 16'(base * (i + 1));
      mem_fill = 1'b1; mem_rdata = d;
      #1;
      chk(is_b ? "b_fill_on" : "a_fill_on", 32'(is_b ? b_fill : a_fill), 32'd1);
      chk(is_b ? "a_fill_off" : "b_fill_off", 32'(is_b ? a_fill : b_fill), 32'd0);
      chk("rdata", 32'(rdata), 32'(d));
      step();
      if (i == 0) begin
        if (is_b) b_req = 1'b0; else a_req = 1'b0;
      end
    end
    mem_fill = 1'b0;
    #1;
    chk("busy_after_burst", 32'(busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    a_addr = '0; b_addr = '0; a_req = 0; b_req = 0; a_rw = 1; b_rw = 1;
    a_wdata = '0; b_wdata = '0; mem_fill = 0; mem_ack = 0; mem_rdata = '0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    step();

    // A read at 0x1000
    a_req = 1; a_rw = 1; a_addr = 32'h1000;
    step();
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1000);
    burst(1'b0, 16'h1111);

    // Simultaneous requests from reset: A first, then B, then A again
    reset = 1'b0;
    step();
    reset = 1'b1;
    a_req = 1; a_rw = 1; a_addr = 32'h0100;
    b_req = 1; b_rw = 1; b_addr = 32'h0200;
    step();
    chk("t2_first_a", mem_addr, 32'h0100);
    burst(1'b0, 16'h0101);
    step();
    chk("t2_then_b_req", 32'(mem_req), 32'd1);
    chk("t2_then_b", mem_addr, 32'h0200);
    burst(1'b1, 16'h0202);
    a_req = 1; b_req = 1;
    step();
    chk("t2_rr_a", mem_addr, 32'h0100);
    burst(1'b0, 16'h0303);
    step();
    chk("t2_rr_b", mem_addr, 32'h0200);
    burst(1'b1, 16'h0404);

    // B write 0xBEEF to 0x2002, req held after ack
    b_req = 1; b_rw = 0; b_addr = 32'h2002; b_wdata = 16'hBEEF;
    step();
    chk("t3_wdata", 32'(mem_wdata), 32'h0000BEEF);
    chk("t3_rw", 32'(mem_rw), 32'd0);
    chk("t3_addr", mem_addr, 32'h2002);
    step();
    mem_ack = 1;
    #1;
    chk("t3_b_ack", 32'(b_ack), 32'd1);
    chk("t3_a_ack", 32'(a_ack), 32'd0);
    step();
    mem_ack = 0;
    step();
    step();
    chk("t3_no_regrant", 32'(mem_req), 32'd0);
    chk("t3_held_busy", 32'(busy), 32'd1);
    b_req = 0;
    step();
    chk("t3_idle", 32'(busy), 32'd0);
    b_rw = 1;

    // Reset after 2 of 4 fills
    a_req = 1; a_rw = 1; a_addr = 32'h4000;
    step();
    mem_fill = 1; mem_rdata = 16'hAAAA;
    step();
    a_req = 0;
    step();
    reset = 0;
    step();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_a_fill", 32'(a_fill), 32'd0);
    chk("t4_mem_addr", mem_addr, 32'd0);
    chk("t4_mem_rw", 32'(mem_rw), 32'd1);
    reset = 1;
    step();
    chk("t4_late_fill", 32'(a_fill), 32'd0);
    step();
    mem_fill = 0;

    // A aborts before any fill; pending B write is granted
    a_req = 1; a_rw = 1; a_addr = 32'h5000;
    b_req = 1; b_rw = 0; b_addr = 32'h3000; b_wdata = 16'h5555;
    step();
    chk("t5_a_granted", mem_addr, 32'h5000);
    a_req = 0;
    step();
    chk("t5_abort_req", 32'(mem_req), 32'd0);
    chk("t5_abort_idle", 32'(busy), 32'd0);
    step();
    chk("t5_b_granted", mem_addr, 32'h3000);
    chk("t5_b_wdata", 32'(mem_wdata), 32'h00005555);
    mem_ack = 1;
    step();
    mem_ack = 0; b_req = 0;
    step();
    b_rw = 1;

    // Spurious responses while idle
    mem_fill = 1; mem_ack = 1;
    #1;
    chk("t6_a_fill", 32'(a_fill), 32'd0);
    chk("t6_b_fill", 32'(b_fill), 32'd0);
    chk("t6_a_ack", 32'(a_ack), 32'd0);
    chk("t6_b_ack", 32'(b_ack), 32'd0);
    step();
    chk("t6_state", 32'(state_o), 32'(IDLE));
    mem_fill = 0; mem_ack = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
